// File: rtl/comp_pkg.sv
// Shared definitions for the two's-complement / sign-magnitude converters.
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } comp_state_t;

    // Sign-magnitude code (width bits, MSB = sign) to two's complement.
    // Negative zero maps to zero.
    function automatic logic [31:0] sm_to_comp(input logic [31:0] sm, input int unsigned width);
        logic [31:0] mask;
        logic [31:0] mag;
        logic [31:0] word_mask;
        mask      = (32'h1 << (width - 1)) - 32'h1;
        word_mask = (mask << 1) | 32'h1;
        mag       = sm & mask;
        if (sm[width-1]) begin
            return (~mag + 32'h1) & word_mask;
        end
        return mag;
    endfunction

    // True when a sign-magnitude code is the negative-zero pattern.
    function automatic logic is_neg_zero(input logic [31:0] sm, input int unsigned width);
        logic [31:0] mask;
        mask = (32'h1 << (width - 1)) - 32'h1;
        return sm[width-1] && ((sm & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/neg_bit_cell.sv
// One step of LSB-first serial negation: bits pass through until the first
// one has been seen, every later bit is inverted.
module neg_bit_cell (
    input  logic b,
    input  logic seen_one,
    output logic out_bit,
    output logic seen_one_next
);

    assign out_bit       = seen_one ? ~b : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/comp_to_abs_serial.sv
// Two's complement to sign-magnitude converter. Non-negative words pass
// straight through; negative words are negated one magnitude bit per cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for a word
// ST_SHIFT | negating magnitude bits 0..DATA_WIDTH-2, one per cycle
// ST_DONE  | out_valid high, result held until the consumer takes it
module comp_to_abs_serial
    import comp_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ovf
);

    localparam int MW = DATA_WIDTH - 1;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 2);

    comp_state_t   state;
    comp_state_t   nxt;
    logic [MW-1:0] mag_q;
    logic [MW-1:0] mag_fin;
    logic [CW-1:0] cnt_q;
    logic          sign_q;
    logic          seen_one_q;
    logic          bit_in;
    logic          bit_out;
    logic          seen_next;
    logic          accept;
    logic          last_bit;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CNT_LAST);
    assign bit_in   = mag_q[cnt_q];

    neg_bit_cell u_neg_bit_cell (
        .b             (bit_in),
        .seen_one      (seen_one_q),
        .out_bit       (bit_out),
        .seen_one_next (seen_next)
    );

    // Magnitude with the bit under the counter replaced by its negated value.
    always_comb begin
        mag_fin        = mag_q;
        mag_fin[cnt_q] = bit_out;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt = in_data[DATA_WIDTH-1] ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    nxt = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they read low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (nxt == ST_IDLE);
            out_valid <= (nxt == ST_DONE);
        end
    end

    // Input capture, serial negation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q      <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            seen_one_q <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mag_q      <= in_data[MW-1:0];
                        sign_q     <= in_data[DATA_WIDTH-1];
                        cnt_q      <= '0;
                        seen_one_q <= 1'b0;
                        if (!in_data[DATA_WIDTH-1]) begin
                            out_data <= in_data;
                            out_ovf  <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    mag_q      <= mag_fin;
                    seen_one_q <= seen_next;
                    if (!last_bit) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (seen_next) begin
                        out_data <= {sign_q, mag_fin};
                        out_ovf  <= 1'b0;
                    end else begin
                        // Most negative value: no magnitude fits, saturate.
                        out_data <= '1;
                        out_ovf  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
